// File: rtl/burst_rom.sv
// rtl/burst_rom.sv - fixed-content ROM streamed out as address-wrapping bursts
module burst_rom #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              oeb,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy
);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_q, data_d;

    // Contents are a pure function of the address, so no storage array is needed.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) ^ MAGIC);
    endfunction

    assign addr_next = addr_q + 1'b1;
    assign rd_valid  = (state_q == READ);
    assign busy      = rd_valid;
    assign rd_last   = rd_valid && (cnt_q == '0);
    assign data      = oeb ? {DATA_W{1'bz}} : data_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = rom_word(start_addr);
                    addr_d  = start_addr;
                    cnt_d   = len_m1;
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_ready) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_next;
                        data_d = rom_word(addr_next);
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_burst_rom.sv
// tb/tb_burst_rom.sv - scoreboard bench for burst_rom
module tb_burst_rom;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic [3:0] len_m1;
    logic       oeb;
    logic       rd_ready;
    tri1  [7:0] data_bus;
    logic       rd_valid;
    logic       rd_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    burst_rom dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .len_m1(len_m1),
        .oeb(oeb),
        .rd_ready(rd_ready),
        .data(data_bus),
        .rd_valid(rd_valid),
        .rd_last(rd_last),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        exp_q.push_back({d, last});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] a, input logic [3:0] l);
        start_addr = a;
        len_m1     = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input logic [7:0] held);
        bit done = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        check("idle_timeout", {31'b0, done}, 32'd1);
        check("idle_valid", {31'b0, rd_valid}, 32'd0);
        check("idle_last", {31'b0, rd_last}, 32'd0);
        check("idle_hold", {24'b0, data_bus}, {24'b0, held});
        check("sb_drained", exp_q.size(), 32'd0);
        step();
    endtask

    // Monitor: every word accepted by the consumer must match the head of the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {23'b0, data_bus, rd_last}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", {24'b0, data_bus}, {24'b0, e[8:1]});
                    check("word_last", {31'b0, rd_last}, {31'b0, e[0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; start_addr = 4'd7; len_m1 = 4'd2;
        oeb = 1'b0; rd_ready = 1'b1;
        step(); step();
        @(negedge clk);
        check("rst_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_last", {31'b0, rd_last}, 32'd0);
        check("rst_data", {24'b0, data_bus}, 32'h00);
        step();
        rst = 1'b0; start = 1'b0;
        step();

        // Basic burst from address 0.
        push(8'hA5, 0); push(8'hA4, 0); push(8'hA7, 0); push(8'hA6, 1);
        pulse_start(4'd0, 4'd3);
        wait_idle(8'hA6);

        // Wrap 15 -> 0; start held high during the last-word cycle is ignored.
        push(8'hAB, 0); push(8'hAA, 0); push(8'hA5, 0); push(8'hA4, 1);
        pulse_start(4'd14, 4'd3);
        step(); step(); step();
        start_addr = 4'd9; len_m1 = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("last_start_ignored", {31'b0, busy}, 32'd0);
        check("sb_wrap", exp_q.size(), 32'd0);
        step();

        // Stall for three cycles on the first word.
        rd_ready = 1'b0;
        push(8'hA7, 0); push(8'hA6, 0); push(8'hA1, 1);
        pulse_start(4'd2, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, rd_valid}, 32'd1);
            check("stall_data", {24'b0, data_bus}, 32'hA7);
            step();
        end
        rd_ready = 1'b1;
        wait_idle(8'hA1);

        // Output disabled: the bus floats (pulled to all ones) while the handshake is unchanged.
        oeb = 1'b1;
        push(8'hFF, 0); push(8'hFF, 0); push(8'hFF, 0); push(8'hFF, 1);
        pulse_start(4'd0, 4'd3);
        wait_idle(8'hFF);
        oeb = 1'b0;
        @(negedge clk);
        check("oeb_release", {24'b0, data_bus}, 32'hA6);
        step();

        // Start mid-burst is ignored; reset during word 2 aborts.
        push(8'hA5, 0);
        pulse_start(4'd0, 4'd15);
        start_addr = 4'd9; start = 1'b1;
        step();
        start = 1'b0; rst = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        check("word2_data", {24'b0, data_bus}, 32'hA4);
        step();
        @(negedge clk);
        check("abort_valid", {31'b0, rd_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_data", {24'b0, data_bus}, 32'h00);
        check("sb_abort", exp_q.size(), 32'd0);
        step();
        rst = 1'b0; rd_ready = 1'b1;
        step();

        // Full-depth burst with wrap; inputs change after the start edge.
        push(8'hA0, 0); push(8'hA3, 0); push(8'hA2, 0); push(8'hAD, 0);
        push(8'hAC, 0); push(8'hAF, 0); push(8'hAE, 0); push(8'hA9, 0);
        push(8'hA8, 0); push(8'hAB, 0); push(8'hAA, 0); push(8'hA5, 0);
        push(8'hA4, 0); push(8'hA7, 0); push(8'hA6, 0); push(8'hA1, 1);
        pulse_start(4'd5, 4'd15);
        start_addr = 4'd0; len_m1 = 4'd0;
        wait_idle(8'hA1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_rom.md
BURST_ROM -- requirements
Module: burst_rom

Interface
REQ-001 Parameter DATA_W, default 8: ROM word width in bits; legal range 1..32.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter MAGIC, default 8'hA5: content seed, zero-extended or truncated to DATA_W.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  burst request pulse; sampled only in IDLE.
REQ-007 Port start_addr  input  ADDR_W  first word address of the burst.
REQ-008 Port len_m1  input  ADDR_W  burst length minus one; bursts are 1..DEPTH words.
REQ-009 Port oeb  input  1  active-low output enable for data; asynchronous, combinational effect.
REQ-010 Port rd_ready  input  1  consumer accepts the current word when high.
REQ-011 Port data  output  DATA_W  tri-state read data; high-Z whenever oeb=1.
REQ-012 Port rd_valid  output  1  data register holds a valid burst word.
REQ-013 Port rd_last  output  1  current valid word is the final word of the burst.
REQ-014 Port busy  output  1  burst in progress (state READ).

Function
REQ-015 ROM contents SHALL be word[i] = (i XOR MAGIC) truncated to DATA_W, for i in 0..DEPTH-1; read-only, no write path.
REQ-016 The FSM SHALL have exactly two states, IDLE and READ; busy = 1 only in READ.
REQ-017 In IDLE, start=1 SHALL, at that edge, load the data register with word[start_addr], load the address counter with start_addr, load the remaining count with len_m1, and enter READ.
REQ-018 Latency SHALL be one cycle: rd_valid rises on the first edge after start is sampled.
REQ-019 In READ, rd_valid SHALL be 1 continuously; a word transfers on each edge where rd_valid=1 and rd_ready=1.
REQ-020 On a transfer with remaining count > 0, the address SHALL increment modulo DEPTH, the data register SHALL load the word at the new address, and the count SHALL decrement, so back-to-back words are delivered one per cycle.
REQ-021 Address wrap SHALL be silent: after DEPTH-1 the next address is 0, with no flag.
REQ-022 rd_last SHALL equal rd_valid AND (remaining count == 0).
REQ-023 On a transfer with rd_last=1, the FSM SHALL return to IDLE, with rd_valid=0 and busy=0 on the next cycle; the data register holds its last value.
REQ-024 With rd_ready=0 in READ (stall), the data register, address, count and rd_valid SHALL hold unchanged for any number of cycles.
REQ-025 start SHALL be ignored while in READ, including the cycle in which the last word transfers; a new burst needs start asserted in IDLE.
REQ-026 data SHALL equal the data register when oeb=0 and high-Z when oeb=1; oeb SHALL NOT affect rd_valid, rd_last, the handshake or any state.
REQ-027 start_addr and len_m1 SHALL be sampled only on the start edge; later changes do not affect a burst in progress.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, with rd_valid=0, rd_last=0, busy=0, data register=0, address=0 and count=0, overriding start and rd_ready.
REQ-029 Reset mid-burst SHALL abort the burst with no further valid words; rst has no effect on data tri-state control beyond the register value.

Verification
REQ-030 Defaults; rst, then start_addr=0, len_m1=3, start=1 for one cycle, rd_ready=1, oeb=0 -> data A5, A4, A7, A6 on 4 consecutive cycles, rd_last only with A6, then busy=0.
REQ-031 start_addr=14, len_m1=3 -> words AB, AA, A5, A4 (wrap 15->0).
REQ-032 Burst start_addr=2, len_m1=2; rd_ready low for 3 cycles after the first word -> A7 held stable with rd_valid=1, then A6, A1 delivered, no word lost or repeated.
REQ-033 oeb=1 throughout a burst -> data is Z on every cycle; handshake and rd_last timing identical to oeb=0.
REQ-034 start pulsed mid-burst, and rst asserted during word 2 of a 16-word burst -> start ignored; next cycle after rst rd_valid=0, busy=0, data register=0.
REQ-035 len_m1=15 with start_addr=5 -> exactly 16 words, address 5..15,0..4, rd_last on word at address 4 (A1).
